// File: rtl/datamemory_sized.sv
// Byte-addressable data memory of DEPTH 32-bit words: sized stores, sized/extended loads
// with one-cycle latency, misalignment detection and optional zero-fill after reset.
//
// state | meaning
// INIT  | writing zero to word init_cnt each cycle, requests refused
// IDLE  | accepting one request per cycle
module datamemory_sized #(
  parameter int DEPTH      = 256,
  parameter int INIT_CLEAR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rvalid,
  output logic        ready,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_t;
  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? INIT : IDLE;

  logic [31:0]   mem [DEPTH];
  state_t        state, state_d;
  logic [AW-1:0] init_cnt, init_cnt_d;
  logic          init_we;
  logic [AW-1:0] idx;
  logic          accept, mis, do_store, do_load;
  logic [3:0]    lane_en;
  logic [31:0]   wdata, rword, load_val;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          addr_unused;

  // FSM state register; ready is registered from the next state so it is
  // low throughout reset and rises on the edge that leaves INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_STATE;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_d;
      init_cnt <= init_cnt_d;
      ready    <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d    = state;
    init_cnt_d = init_cnt;
    init_we    = 1'b0;
    case (state)
      INIT: begin
        init_we    = 1'b1;
        init_cnt_d = init_cnt + AW'(1);
        if (init_cnt == LAST_IDX) state_d = IDLE;
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: state_d = RST_STATE;
    endcase
  end

  // Request decode
  assign idx         = addr[AW+1:2];
  assign addr_unused = ^addr[31:AW+2];
  assign accept      = req & ready;
  assign mis         = (size == 2'b11) |
                       ((size == 2'b01) & addr[0]) |
                       ((size == 2'b10) & (addr[1:0] != 2'b00));
  assign do_store    = accept & we & ~mis;
  assign do_load     = accept & ~we & ~mis;

  always_comb begin
    lane_en = 4'b0000;
    wdata   = data_in;
    case (size)
      2'b00: begin
        lane_en = 4'b0001 << addr[1:0];
        wdata   = {4{data_in[7:0]}};
      end
      2'b01: begin
        lane_en = addr[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data_in[15:0]}};
      end
      2'b10: begin
        lane_en = 4'b1111;
        wdata   = data_in;
      end
      default: begin
        lane_en = 4'b0000;
        wdata   = data_in;
      end
    endcase
  end

  // Storage is not reset; INIT zero-fill and stores are mutually exclusive
  // because ready is low for the whole of INIT.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
    end else if (do_store) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Load path: pick the addressed lane(s), right-align, extend
  assign rword = mem[idx];

  always_comb begin
    ld_byte = rword[7:0];
    case (addr[1:0])
      2'b00: ld_byte = rword[7:0];
      2'b01: ld_byte = rword[15:8];
      2'b10: ld_byte = rword[23:16];
      2'b11: ld_byte = rword[31:24];
      default: ld_byte = rword[7:0];
    endcase
    ld_half = addr[1] ? rword[31:16] : rword[15:0];
    case (size)
      2'b00:   load_val = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{sign_ext & ld_half[15]}}, ld_half};
      default: load_val = rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= '0;
      rvalid       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      rvalid       <= do_load;
      misalign_err <= accept & mis;
      if (do_load) data_out <= load_val;
    end
  end

endmodule

// File: tb/tb_datamemory_sized.sv
// Scoreboard bench for datamemory_sized (DEPTH=16, INIT_CLEAR=1): expected
// responses are queued as requests are driven and compared a cycle later.
module tb_datamemory_sized;

  localparam int DEPTH = 16;

  typedef struct {
    logic        req;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic        sx;
    logic [31:0] exp;
    logic        use_model;
  } stim_t;

  typedef struct {
    logic        rv;
    logic        err;
    logic [31:0] dout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, data_in = '0;
  logic [31:0] data_out;
  logic        rvalid, ready, misalign_err;

  int          checks = 0, errors = 0;
  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_dout = '0;

  datamemory_sized #(.DEPTH(DEPTH), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .data_in(data_in), .data_out(data_out), .rvalid(rvalid),
    .ready(ready), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic r, input logic w, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic sx, input logic [31:0] exp);
    stim_t s;
    s.req = r; s.we = w; s.sz = sz; s.a = a; s.d = d; s.sx = sx; s.exp = exp;
    s.use_model = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sx);
    logic [31:0] sh;
    sh = model[a[5:2]] >> (8 * a[1:0]);
    if (sz == 2'b00) return {{24{sx & sh[7]}}, sh[7:0]};
    if (sz == 2'b01) return {{16{sx & sh[15]}}, sh[15:0]};
    return model[a[5:2]];
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) model[a[5:2]][8*a[1:0] +: 8] = d[7:0];
    else if (sz == 2'b01) model[a[5:2]][16*a[1] +: 16] = d[15:0];
    else model[a[5:2]] = d;
  endtask

  // Drive one request (called at a falling edge) and queue its expected response
  task automatic drive(input stim_t s);
    exp_t e;
    logic bad;
    req = s.req; we = s.we; size = s.sz; addr = s.a; data_in = s.d; sign_ext = s.sx;
    bad = s.req && ((s.sz == 2'b11) || (s.sz == 2'b01 && s.a[0]) ||
                    (s.sz == 2'b10 && s.a[1:0] != 2'b00));
    e.err = bad;
    e.rv  = s.req && !s.we && !bad;
    if (e.rv) last_dout = s.use_model ? mdl_load(s.a, s.sz, s.sx) : s.exp;
    e.dout = last_dout;
    if (s.req && s.we && !bad) mdl_store(s.a, s.sz, s.d);
    sb.push_back(e);
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_dout = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || misalign_err !== 1'b0 || data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rvalid=%b err=%b data_out=%h, want 0/0/0/00000000",
               ready, rvalid, misalign_err, data_out);
    end
    rst_n = 1'b1;
    #1 n = 0;
    while (!ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL init_ready_low: ready low for %0d cycles, want %0d", n, DEPTH);
    end
  endtask

  task automatic test_clear();
    stim_t s[$];
    exp_t  e;
    for (int i = 0; i < DEPTH; i++) s.push_back(mk(1, 0, 2'b10, 32'(4 * i), 0, 0, 32'h0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL clear[%0d]: scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if (rvalid !== e.rv || misalign_err !== e.err || data_out !== e.dout) begin
          errors++;
          $display("FAIL clear[%0d]: rvalid=%b err=%b data_out=%h, want %b/%b/%h",
                   i, rvalid, misalign_err, data_out, e.rv, e.err, e.dout);
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1, 1, 2'b10, 32'h8, 32'h80FF_7F01, 0, 0));
    s.push_back(mk(1, 0, 2'b00, 32'h8, 0, 1, 32'h0000_0001));
    s.push_back(mk(1, 0, 2'b00, 32'h9, 0, 1, 32'h0000_007F));
    s.push_back(mk(1, 0, 2'b00, 32'hA, 0, 1, 32'hFFFF_FFFF));
    s.push_back(mk(1, 0, 2'b00, 32'hB, 0, 1, 32'hFFFF_FF80));
    s.push_back(mk(0, 0, 2'b00, 32'h0, 0, 0, 0));
    s.push_back(mk(1, 0, 2'b00, 32'hB, 0, 0, 32'h0000_0080));
    s.push_back(mk(1, 0, 2'b01, 32'hA, 0, 1, 32'hFFFF_80FF));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL bytes[%0d]: scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if (rvalid !== e.rv || misalign_err !== e.err || data_out !== e.dout) begin
          errors++;
          $display("FAIL bytes[%0d]: rvalid=%b err=%b data_out=%h, want %b/%b/%h",
                   i, rvalid, misalign_err, data_out, e.rv, e.err, e.dout);
        end
      end
    end
  endtask

  task automatic test_merge_and_misalign();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(1, 1, 2'b10, 32'h10, 32'h1122_3344, 0, 0));
    s.push_back(mk(1, 1, 2'b00, 32'h11, 32'h0000_00AB, 0, 0));
    s.push_back(mk(1, 0, 2'b10, 32'h10, 0, 0, 32'h1122_AB44));
    s.push_back(mk(1, 0, 2'b01, 32'h12, 0, 0, 32'h0000_1122));
    s.push_back(mk(1, 0, 2'b10, 32'h6, 0, 0, 0));
    s.push_back(mk(1, 1, 2'b01, 32'h3, 32'hFFFF_FFFF, 0, 0));
    s.push_back(mk(1, 0, 2'b11, 32'h0, 0, 0, 0));
    s.push_back(mk(1, 1, 2'b11, 32'h10, 32'hFFFF_FFFF, 0, 0));
    s.push_back(mk(1, 1, 2'b10, 32'h12, 32'hFFFF_FFFF, 0, 0));
    s.push_back(mk(1, 0, 2'b10, 32'h10, 0, 0, 32'h1122_AB44));
    s.push_back(mk(1, 0, 2'b10, 32'h0, 0, 0, 32'h0000_0000));
    s.push_back(mk(1, 1, 2'b10, 32'h40, 32'hDEAD_BEEF, 0, 0));
    s.push_back(mk(1, 0, 2'b10, 32'h0, 0, 0, 32'hDEAD_BEEF));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL merge[%0d]: scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if (rvalid !== e.rv || misalign_err !== e.err || data_out !== e.dout) begin
          errors++;
          $display("FAIL merge[%0d]: rvalid=%b err=%b data_out=%h, want %b/%b/%h",
                   i, rvalid, misalign_err, data_out, e.rv, e.err, e.dout);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 80; i++) begin
      s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 1) == 1, 0);
      if (s.sz == 2'b11 && $urandom_range(0, 3) != 0) s.sz = 2'b10;
      if (s.sz == 2'b01 && $urandom_range(0, 3) != 0) s.a[0] = 1'b0;
      if (s.sz == 2'b10 && $urandom_range(0, 3) != 0) s.a[1:0] = 2'b00;
      s.use_model = 1'b1;
      drive(s);
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL random[%0d]: scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if (rvalid !== e.rv || misalign_err !== e.err || data_out !== e.dout) begin
          errors++;
          $display("FAIL random[%0d]: rvalid=%b err=%b data_out=%h, want %b/%b/%h",
                   i, rvalid, misalign_err, data_out, e.rv, e.err, e.dout);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    exp_t  e;
    int    n;
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h8;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checks++;
    if (rvalid !== 1'b0 || misalign_err !== 1'b0 || data_out !== 32'h0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_during_access: rvalid=%b err=%b data_out=%h ready=%b, want all 0",
               rvalid, misalign_err, data_out, ready);
    end
    req = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_ready: ready=%b at INIT cycle 8, want 0", ready);
    end
    rst_n = 1'b0;
    #1 checks++;
    if (ready !== 1'b0 || data_out !== 32'h0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_reset: ready=%b data_out=%h rvalid=%b, want 0", ready, data_out, rvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 n = 0;
    while (!ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== DEPTH) begin
      errors++;
      $display("FAIL reinit_ready_low: ready low for %0d cycles, want %0d", n, DEPTH);
    end
    s.push_back(mk(1, 0, 2'b10, 32'h8, 0, 0, 32'h0));
    s.push_back(mk(1, 0, 2'b10, 32'h10, 0, 0, 32'h0));
    s.push_back(mk(1, 0, 2'b10, 32'h0, 0, 0, 32'h0));
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL recleared[%0d]: scoreboard empty", i); end
      else begin
        e = sb.pop_front();
        if (rvalid !== e.rv || misalign_err !== e.err || data_out !== e.dout) begin
          errors++;
          $display("FAIL recleared[%0d]: rvalid=%b err=%b data_out=%h, want %b/%b/%h",
                   i, rvalid, misalign_err, data_out, e.rv, e.err, e.dout);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_lanes();
    test_merge_and_misalign();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
